// File: rtl/mda_text_writer.sv
`default_nettype none
// ============================================================================
// Module   : mda_text_writer
// Purpose  : Byte-stream writer for the 80x25 MDA character RAM. Interprets
//            CR/LF/BS/FF/ESC-attribute, auto-wraps and scrolls via RAM copy.
// Revision : 1.0  initial release
// ============================================================================
module mda_text_writer #(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 25,
    parameter logic [7:0] BLANK_CODE = 8'h20,
    parameter logic [7:0] BLANK_ATTR = 8'h07
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic [7:0]  wr_code,
    output logic [7:0]  wr_attr,
    output logic [10:0] rd_addr,
    input  logic [7:0]  rd_code,
    input  logic [7:0]  rd_attr,
    output logic [6:0]  cur_col,
    output logic [4:0]  cur_row,
    output logic        busy
);

    localparam logic [6:0]  c_LAST_COL = 7'(COLS - 1);
    localparam logic [4:0]  c_LAST_ROW = 5'(ROWS - 1);
    localparam logic [10:0] c_COLS     = 11'(COLS);
    localparam logic [10:0] c_COPY     = 11'((ROWS - 1) * COLS);
    localparam logic [10:0] c_CELLS    = 11'(ROWS * COLS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ESC       = 3'd1,
        S_SCROLL    = 3'd2,
        S_FILL_ROW  = 3'd3,
        S_CLEAR_ALL = 3'd4
    } state_t;

    state_t      r_state, w_state_n;
    logic [6:0]  r_col, w_col_n;
    logic [4:0]  r_row, w_row_n;
    logic [7:0]  r_attr, w_attr_n;
    logic [10:0] r_cnt, w_cnt_n;
    logic        r_wr_en, w_wr_en_n;
    logic [10:0] r_wr_addr, w_wr_addr_n;
    logic [7:0]  r_wr_code, w_wr_code_n;
    logic [7:0]  r_wr_attr, w_wr_attr_n;
    logic [10:0] r_rd_addr, w_rd_addr_n;
    logic        r_in_ready, w_in_ready_n;
    logic        r_busy, w_busy_n;
    logic        w_accept;
    logic        w_lf_req;
    logic [10:0] w_cell_addr;

    assign w_accept    = in_valid & r_in_ready;
    // row*80 as (row<<6)+(row<<4), avoiding a multiplier
    assign w_cell_addr = {r_row, 6'b0} + {2'b0, r_row, 4'b0} + {4'b0, r_col};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_attr     <= BLANK_ATTR;
            r_cnt      <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_code  <= '0;
            r_wr_attr  <= '0;
            r_rd_addr  <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_col      <= w_col_n;
            r_row      <= w_row_n;
            r_attr     <= w_attr_n;
            r_cnt      <= w_cnt_n;
            r_wr_en    <= w_wr_en_n;
            r_wr_addr  <= w_wr_addr_n;
            r_wr_code  <= w_wr_code_n;
            r_wr_attr  <= w_wr_attr_n;
            r_rd_addr  <= w_rd_addr_n;
            r_in_ready <= w_in_ready_n;
            r_busy     <= w_busy_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_col_n     = r_col;
        w_row_n     = r_row;
        w_attr_n    = r_attr;
        w_cnt_n     = r_cnt;
        w_wr_en_n   = 1'b0;
        w_wr_addr_n = r_wr_addr;
        w_wr_code_n = r_wr_code;
        w_wr_attr_n = r_wr_attr;
        w_rd_addr_n = r_rd_addr;
        w_lf_req    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (in_data)
                        8'h0D: w_col_n = '0;
                        8'h0A: w_lf_req = 1'b1;
                        8'h08: begin
                            if (r_col != '0) w_col_n = r_col - 7'd1;
                        end
                        8'h0C: begin
                            w_state_n = S_CLEAR_ALL;
                            w_cnt_n   = '0;
                            w_col_n   = '0;
                            w_row_n   = '0;
                        end
                        8'h1B: w_state_n = S_ESC;
                        default: begin
                            w_wr_en_n   = 1'b1;
                            w_wr_addr_n = w_cell_addr;
                            w_wr_code_n = in_data;
                            w_wr_attr_n = r_attr;
                            if (r_col == c_LAST_COL) begin
                                w_col_n  = '0;
                                w_lf_req = 1'b1;
                            end else begin
                                w_col_n = r_col + 7'd1;
                            end
                        end
                    endcase
                    if (w_lf_req) begin
                        if (r_row == c_LAST_ROW) begin
                            w_state_n   = S_SCROLL;
                            w_cnt_n     = '0;
                            w_rd_addr_n = c_COLS;
                        end else begin
                            w_row_n = r_row + 5'd1;
                        end
                    end
                end
            end

            S_ESC: begin
                if (w_accept) begin
                    w_attr_n  = in_data;
                    w_state_n = S_IDLE;
                end
            end

            // Cycle k reads 80+k; data returns in cycle k+1 and is registered
            // as the write of cell k, so the write stream trails reads by one.
            S_SCROLL: begin
                if (r_cnt != '0) begin
                    w_wr_en_n   = 1'b1;
                    w_wr_addr_n = r_cnt - 11'd1;
                    w_wr_code_n = rd_code;
                    w_wr_attr_n = rd_attr;
                end
                if (r_cnt < c_COPY - 11'd1) begin
                    w_rd_addr_n = r_cnt + c_COLS + 11'd1;
                end
                if (r_cnt == c_COPY) begin
                    w_state_n = S_FILL_ROW;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + 11'd1;
                end
            end

            S_FILL_ROW: begin
                w_wr_en_n   = 1'b1;
                w_wr_addr_n = c_COPY + r_cnt;
                w_wr_code_n = BLANK_CODE;
                w_wr_attr_n = BLANK_ATTR;
                if (r_cnt == c_COLS - 11'd1) begin
                    w_state_n = S_IDLE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + 11'd1;
                end
            end

            S_CLEAR_ALL: begin
                w_wr_en_n   = 1'b1;
                w_wr_addr_n = r_cnt;
                w_wr_code_n = BLANK_CODE;
                w_wr_attr_n = BLANK_ATTR;
                if (r_cnt == c_CELLS - 11'd1) begin
                    w_state_n = S_IDLE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = r_cnt + 11'd1;
                end
            end

            default: w_state_n = S_IDLE;
        endcase

        w_in_ready_n = (w_state_n == S_IDLE) || (w_state_n == S_ESC);
        w_busy_n     = (w_state_n == S_SCROLL) || (w_state_n == S_FILL_ROW) ||
                       (w_state_n == S_CLEAR_ALL);
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_code  = r_wr_code;
    assign wr_attr  = r_wr_attr;
    assign rd_addr  = r_rd_addr;
    assign cur_col  = r_col;
    assign cur_row  = r_row;

endmodule
`default_nettype wire

// File: tb/tb_mda_text_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mda_text_writer
// Purpose  : Scoreboard bench for mda_text_writer with a character RAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mda_text_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_code;
    logic [7:0]  wr_attr;
    logic [10:0] rd_addr;
    logic [7:0]  rd_code;
    logic [7:0]  rd_attr;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;

    always #5 clk = ~clk;

    mda_text_writer dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_code(wr_code), .wr_attr(wr_attr),
        .rd_addr(rd_addr), .rd_code(rd_code), .rd_attr(rd_attr),
        .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
    );

    typedef struct packed {
        logic [10:0] a;
        logic [7:0]  c;
        logic [7:0]  t;
    } wr_t;

    wr_t        q[$];
    wr_t        mon_e;
    int         errors = 0;
    int         checks = 0;

    logic [7:0] ram_code [2000];
    logic [7:0] ram_attr [2000];
    logic [7:0] exp_code [2000];
    logic [7:0] exp_attr [2000];

    int         m_col, m_row;
    logic [7:0] m_attr;
    bit         m_esc;

    // RAM with one-cycle registered read
    always @(posedge clk) begin
        if (wr_en) begin
            ram_code[wr_addr] <= wr_code;
            ram_attr[wr_addr] <= wr_attr;
        end
        rd_code <= ram_code[rd_addr];
        rd_attr <= ram_attr[rd_addr];
    end

    always @(negedge clk) begin
        if (rst) begin
            if (wr_en) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%0d code=%h attr=%h", wr_addr, wr_code, wr_attr);
                end else begin
                    mon_e = q.pop_front();
                    if ({wr_addr, wr_code, wr_attr} !== mon_e) begin
                        errors++;
                        $display("FAIL write: got addr=%0d code=%h attr=%h, want addr=%0d code=%h attr=%h",
                                 wr_addr, wr_code, wr_attr, mon_e.a, mon_e.c, mon_e.t);
                    end
                end
            end
            if (busy) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_while_busy: in_ready=%b want 0", in_ready);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic exp_write(input int addr, input logic [7:0] c, input logic [7:0] t);
        q.push_back('{a: 11'(addr), c: c, t: t});
        exp_code[addr] = c;
        exp_attr[addr] = t;
    endtask

    task automatic m_lf();
        if (m_row < 24) m_row++;
        else begin
            for (int i = 0; i < 1920; i++) exp_write(i, exp_code[80 + i], exp_attr[80 + i]);
            for (int i = 1920; i < 2000; i++) exp_write(i, 8'h20, 8'h07);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic put(input logic [7:0] b);
        if (m_esc) begin
            m_attr = b;
            m_esc  = 1'b0;
        end else begin
            case (b)
                8'h0D: m_col = 0;
                8'h0A: m_lf();
                8'h08: if (m_col > 0) m_col--;
                8'h0C: begin
                    m_col = 0;
                    m_row = 0;
                    for (int i = 0; i < 2000; i++) exp_write(i, 8'h20, 8'h07);
                end
                8'h1B: m_esc = 1'b1;
                default: begin
                    exp_write(m_row * 80 + m_col, b, m_attr);
                    if (m_col == 79) begin
                        m_col = 0;
                        m_lf();
                    end else m_col++;
                end
            endcase
        end
        send(b);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!(q.size() == 0 && busy === 1'b0 && in_ready === 1'b1) && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: pending=%0d want 0", name, q.size());
        end
    endtask

    task automatic check_cursor(input string name);
        wait_idle(name);
        check({name, "_col"}, int'(cur_col), m_col);
        check({name, "_row"}, int'(cur_row), m_row);
    endtask

    initial begin
        int mism;
        int n;
        for (int i = 0; i < 2000; i++) begin
            ram_code[i] = 8'(i) ^ 8'h5A;
            ram_attr[i] = 8'(i >> 3);
            exp_code[i] = 8'(i) ^ 8'h5A;
            exp_attr[i] = 8'(i >> 3);
        end
        m_col = 0; m_row = 0; m_attr = 8'h07; m_esc = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_col", int'(cur_col), 0);
        check("rst_row", int'(cur_row), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 check("ready_after_release", int'(in_ready), 1);

        put(8'h41);
        check_cursor("after_A");

        put(8'h0D); put(8'h1B); put(8'h70); put(8'h42);
        check_cursor("esc_attr");

        put(8'h1B); put(8'h07); put(8'h0D);
        for (int i = 0; i < 80; i++) put((i < 3) ? 8'(i) : 8'(8'h20 + i));
        check_cursor("full_row");
        put(8'h08);
        check_cursor("bs_col0");
        put(8'h41); put(8'h08);
        check_cursor("bs_dec");

        for (int i = 0; i < 23; i++) put(8'h0A);
        check_cursor("lf_to_24");
        put(8'h0A);
        check_cursor("lf_scroll");

        for (int i = 0; i < 80; i++) put(8'(8'h61 + (i % 26)));
        check_cursor("wrap_scroll");

        put(8'h1B); put(8'h0F); put(8'h0C);
        check_cursor("ff_clear");
        put(8'h43);
        check_cursor("attr_after_ff");

        repeat (3) @(negedge clk);
        mism = 0;
        for (int i = 0; i < 2000; i++)
            if (ram_code[i] !== exp_code[i] || ram_attr[i] !== exp_attr[i]) mism++;
        check("ram_contents_mismatches", mism, 0);

        for (int i = 0; i < 25; i++) put(8'h0A);
        n = 0;
        while (busy !== 1'b1 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("scroll_started", int'(busy), 1);
        repeat (500) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_wr_en", int'(wr_en), 0);
        check("abort_rd_addr", int'(rd_addr), 0);
        check("abort_row", int'(cur_row), 0);
        q.delete();
        m_col = 0; m_row = 0; m_attr = 8'h07; m_esc = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 check("abort_ready_release", int'(in_ready), 1);
        put(8'h5A);
        check_cursor("after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
